// File: rtl/tristate_bus_pkg.sv
// Purpose : shared types and helpers for the tristate bus arbiter slice.
// Latency : n/a (types and a combinational helper only).
// Backpressure: n/a.
package tristate_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } state_e;

    // First requester strictly after ptr, wrapping over n channels. The
    // channel at ptr itself is reached last, so the previous owner only wins
    // when nobody else is asking. Returns ptr when req is all zero.
    function automatic logic [3:0] rr_next(input logic [15:0] req,
                                           input logic [3:0]  ptr,
                                           input int          n);
        logic [3:0] idx;
        logic       found;
        int         c;
        idx   = ptr;
        found = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (!found && k <= n) begin
                c = int'(ptr) + k;
                if (c >= n) c = c - n;
                if (req[c[3:0]]) begin
                    idx   = c[3:0];
                    found = 1'b1;
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Purpose : channel-side bundle of the tristate bus arbiter (requests, data, shared bus, status).
// Latency : n/a (signal container).
// Backpressure: none; req is a level held by the source until it no longer needs the bus.
// Ports   : req/sig_in from sources; sig_out shared tristate bus; grant/oe one-hot owner;
//           busy and sticky contention_err status.
interface tristate_bus_arbiter_if #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 1
);
    logic [CHANNELS-1:0]       req;
    logic [CHANNELS*WIDTH-1:0] sig_in;
    wire  [WIDTH-1:0]          sig_out;
    logic [CHANNELS-1:0]       grant;
    logic [CHANNELS-1:0]       oe;
    logic                      busy;
    logic                      contention_err;

    modport master (
        output req, sig_in,
        input  sig_out, grant, oe, busy, contention_err
    );

    modport slave (
        input  req, sig_in,
        output sig_out, grant, oe, busy, contention_err
    );
endinterface

// File: rtl/tristate_bus_drv.sv
// Purpose : one bus channel: registers its input (optionally inverted) and drives the shared bus when enabled.
// Latency : 1 cycle from in_i to bus_o; enable acts combinationally.
// Backpressure: none; the register samples every edge regardless of ownership.
// Ports   : clk/rst (async active-low), in_i channel data, en_i output enable,
//           bus_o tristate bus contribution, oe_o enable actually applied.
module tristate_bus_drv #(
    parameter int WIDTH  = 1,
    parameter bit INVERT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_i,
    input  logic             en_i,
    output wire  [WIDTH-1:0] bus_o,
    output logic             oe_o
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    assign q_d = INVERT ? ~in_i : in_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q_q <= '0;
        else      q_q <= q_d;
    end

    assign bus_o = en_i ? q_q : {WIDTH{1'bz}};
    assign oe_o  = en_i;
endmodule

// File: rtl/tristate_bus_arbiter.sv
// Purpose : round-robin owner selection for N channels sharing one tristate bus, with high-Z turnaround and hold preemption.
// Latency : grant 1 cycle after req is sampled; owner data on the bus 1 edge after it is sampled.
// Backpressure: a requester waits (req held) until granted; hold preemption bounds the wait when MAX_HOLD > 0.
// Ports   : clk, rst (async active-low), bus (slave modport: req, sig_in, sig_out, grant, oe, busy, contention_err).
module tristate_bus_arbiter
    import tristate_bus_pkg::*;
#(
    parameter int                  CHANNELS    = 2,
    parameter int                  WIDTH       = 1,
    parameter logic [CHANNELS-1:0] INVERT_MASK = '0,
    parameter int                  TURNAROUND  = 1,
    parameter int                  MAX_HOLD    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    tristate_bus_arbiter_if.slave bus
);
    localparam int         HOLD_W  = (MAX_HOLD > 0)   ? $clog2(MAX_HOLD + 1)   : 1;
    localparam int         TURN_W  = (TURNAROUND > 0) ? $clog2(TURNAROUND + 1) : 1;
    localparam logic [3:0] PTR_RST = 4'(CHANNELS - 1);

    state_e              state_q, state_d;
    logic [CHANNELS-1:0] grant_q, grant_d;
    logic [3:0]          ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [TURN_W-1:0]   turn_q, turn_d;
    logic                cerr_q, cerr_d;

    logic [15:0]         req_ext;
    logic [3:0]          nxt_idx;
    logic [CHANNELS-1:0] one_hot;
    logic [CHANNELS-1:0] oe;
    logic                owner_req;
    logic                preempt;
    logic                arb;

    tri [WIDTH-1:0]      bus_w;

    // Enables come straight from the registered grant, which is cleared by
    // the async reset, so the bus is released without waiting for a clock.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        tristate_bus_drv #(
            .WIDTH  (WIDTH),
            .INVERT (INVERT_MASK[i])
        ) u_drv (
            .clk   (clk),
            .rst   (rst),
            .in_i  (bus.sig_in[i*WIDTH +: WIDTH]),
            .en_i  (grant_q[i]),
            .bus_o (bus_w),
            .oe_o  (oe[i])
        );
    end

    always_comb begin
        req_ext = '0;
        req_ext[CHANNELS-1:0] = bus.req;
    end

    assign nxt_idx   = rr_next(req_ext, ptr_q, CHANNELS);
    assign one_hot   = {{(CHANNELS-1){1'b0}}, 1'b1} << nxt_idx;
    assign owner_req = |(bus.req & grant_q);
    // hold_q counts DRIVE cycles including the current one.
    assign preempt   = (MAX_HOLD != 0) && (int'(hold_q) >= MAX_HOLD)
                       && |(bus.req & ~grant_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        arb     = 1'b0;
        cerr_d  = cerr_q | ($countones(oe) > 1);

        case (state_q)
            ST_IDLE: arb = 1'b1;
            ST_DRIVE: begin
                if (hold_q != '1) hold_d = hold_q + 1'b1;
                if (!owner_req || preempt) begin
                    grant_d = '0;
                    // With no turnaround the release edge also hands over;
                    // the single grant register makes overlap impossible.
                    if (TURNAROUND == 0) begin
                        arb = 1'b1;
                    end else begin
                        state_d = ST_TURN;
                        turn_d  = TURN_W'(TURNAROUND - 1);
                    end
                end
            end
            ST_TURN: begin
                if (turn_q == '0) arb = 1'b1;
                else              turn_d = turn_q - 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        if (arb) begin
            if (|bus.req) begin
                grant_d   = one_hot;
                ptr_d     = nxt_idx;
                state_d   = ST_DRIVE;
                hold_d    = '0;
                hold_d[0] = 1'b1;
            end else begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_RST;
            hold_q  <= '0;
            turn_q  <= '0;
            cerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
            cerr_q  <= cerr_d;
        end
    end

    assign bus.sig_out        = bus_w;
    assign bus.grant          = grant_q;
    assign bus.oe             = oe;
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.contention_err = cerr_q;
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
module tb_tristate_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // A: 2ch/1b, ch1 inverted, 1 turn cycle.  B: 4ch/8b, 2 turn cycles.
    // C: as B with MAX_HOLD=3.  D: 2ch/1b, zero turnaround.
    tristate_bus_arbiter_if #(.CHANNELS(2), .WIDTH(1)) if_a ();
    tristate_bus_arbiter_if #(.CHANNELS(4), .WIDTH(8)) if_b ();
    tristate_bus_arbiter_if #(.CHANNELS(4), .WIDTH(8)) if_c ();
    tristate_bus_arbiter_if #(.CHANNELS(2), .WIDTH(1)) if_d ();

    tristate_bus_arbiter #(.CHANNELS(2), .WIDTH(1), .INVERT_MASK(2'b10),
                           .TURNAROUND(1), .MAX_HOLD(0))
        dut_a (.clk(clk), .rst(rst_n), .bus(if_a));
    tristate_bus_arbiter #(.CHANNELS(4), .WIDTH(8), .INVERT_MASK(4'b0000),
                           .TURNAROUND(2), .MAX_HOLD(0))
        dut_b (.clk(clk), .rst(rst_n), .bus(if_b));
    tristate_bus_arbiter #(.CHANNELS(4), .WIDTH(8), .INVERT_MASK(4'b0000),
                           .TURNAROUND(2), .MAX_HOLD(3))
        dut_c (.clk(clk), .rst(rst_n), .bus(if_c));
    tristate_bus_arbiter #(.CHANNELS(2), .WIDTH(1), .INVERT_MASK(2'b00),
                           .TURNAROUND(0), .MAX_HOLD(0))
        dut_d (.clk(clk), .rst(rst_n), .bus(if_d));

    // Uniform views of the four instances for the monitor.
    logic [3:0] mg  [4];
    logic [3:0] moe [4];
    logic [7:0] md  [4];
    logic       mbusy [4];
    logic       mcerr [4];

    assign mg[0] = {2'b00, if_a.grant};   assign moe[0] = {2'b00, if_a.oe};
    assign mg[1] = if_b.grant;            assign moe[1] = if_b.oe;
    assign mg[2] = if_c.grant;            assign moe[2] = if_c.oe;
    assign mg[3] = {2'b00, if_d.grant};   assign moe[3] = {2'b00, if_d.oe};
    assign md[0] = {7'd0, if_a.sig_out};
    assign md[1] = if_b.sig_out;
    assign md[2] = if_c.sig_out;
    assign md[3] = {7'd0, if_d.sig_out};
    assign mbusy[0] = if_a.busy;  assign mcerr[0] = if_a.contention_err;
    assign mbusy[1] = if_b.busy;  assign mcerr[1] = if_b.contention_err;
    assign mbusy[2] = if_c.busy;  assign mcerr[2] = if_c.contention_err;
    assign mbusy[3] = if_d.busy;  assign mcerr[3] = if_d.contention_err;

    typedef struct {
        int         inst;
        logic [3:0] g;
        logic [7:0] d;
        int         gap;   // required high-Z cycles before this owner, -1 = skip
        int         plen;  // required cycles the previous owner held, -1 = skip
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string nm, input int act, input int req_v);
        checks++;
        if (act != req_v) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req_v, $time);
        end
    endtask

    task automatic expect_grant(input int inst, input logic [3:0] g,
                                input logic [7:0] d, input int gap, input int plen);
        exp_t e;
        e.inst = inst; e.g = g; e.d = d; e.gap = gap; e.plen = plen;
        sbq.push_back(e);
    endtask

    task automatic wait_grant(input int k, input logic [3:0] g, input string nm);
        int n;
        n = 0;
        while (mg[k] != g && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(nm, int'(mg[k]), int'(g));
    endtask

    // Monitor: every new owner pops one expectation; enables checked each cycle.
    logic [3:0] prev_g [4];
    int zero_cnt [4];
    int own_len  [4];
    int last_len [4];

    initial begin
        for (int k = 0; k < 4; k++) begin
            prev_g[k] = 4'd0; zero_cnt[k] = 0; own_len[k] = 0; last_len[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                chk("oe_matches_grant", int'(moe[k]), int'(mg[k]));
                chk("oe_overlap", int'($countones(moe[k]) <= 1), 1);
                if (mg[k] != 4'd0 && mg[k] != prev_g[k]) begin
                    int plen_now;
                    plen_now = (prev_g[k] != 4'd0) ? own_len[k] : last_len[k];
                    if (sbq.size() == 0) begin
                        chk("unexpected_grant", int'(mg[k]), 0);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk("sb_instance", k, e.inst);
                        chk("sb_grant", int'(mg[k]), int'(e.g));
                        chk("sb_data", int'(md[k]), int'(e.d));
                        if (e.gap >= 0)  chk("sb_gap", zero_cnt[k], e.gap);
                        if (e.plen >= 0) chk("sb_hold", plen_now, e.plen);
                    end
                    if (prev_g[k] != 4'd0) last_len[k] = own_len[k];
                    own_len[k]  = 1;
                    zero_cnt[k] = 0;
                end else if (mg[k] != 4'd0) begin
                    own_len[k]++;
                end else begin
                    if (prev_g[k] != 4'd0) last_len[k] = own_len[k];
                    own_len[k] = 0;
                    zero_cnt[k]++;
                end
                prev_g[k] = mg[k];
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog expired at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        if_a.req = '0; if_b.req = '0; if_c.req = '0; if_d.req = '0;
        if_a.sig_in = 2'b11;
        if_b.sig_in = 32'h44332211;
        if_c.sig_in = 32'h44332211;
        if_d.sig_in = 2'b01;

        // Reset state
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("rst_grant", int'(mg[k]), 0);
            chk("rst_oe", int'(moe[k]), 0);
            chk("rst_busy", int'(mbusy[k]), 0);
            chk("rst_cerr", int'(mcerr[k]), 0);
        end
        rst_n = 1'b1;

        // 1: A, ch0 then inverted ch1 after one high-Z cycle
        expect_grant(0, 4'b0001, 8'd1, -1, -1);
        expect_grant(0, 4'b0010, 8'd0,  1, -1);
        @(negedge clk);
        if_a.req = 2'b01;
        @(negedge clk);
        chk("a_grant_latency", int'(mg[0]), 1);
        if_a.sig_in = 2'b10;
        @(negedge clk);
        chk("a_data_follow0", int'(md[0]), 0);
        if_a.sig_in = 2'b11;
        @(negedge clk);
        chk("a_data_follow1", int'(md[0]), 1);
        if_a.req = 2'b10;
        wait_grant(0, 4'b0010, "a_wait_ch1");
        if_a.req = 2'b00;
        repeat (4) @(negedge clk);

        // 4: D, zero turnaround handover on a single edge
        expect_grant(3, 4'b0001, 8'd1, -1, -1);
        expect_grant(3, 4'b0010, 8'd0,  0, -1);
        if_d.req = 2'b11;
        wait_grant(3, 4'b0001, "d_wait_ch0");
        if_d.req = 2'b10;
        wait_grant(3, 4'b0010, "d_wait_ch1");
        if_d.req = 2'b00;
        repeat (3) @(negedge clk);
        chk("d_busy_idle", int'(mbusy[3]), 0);

        // 3: C, MAX_HOLD=3 preemption in both directions
        expect_grant(2, 4'b0001, 8'h11, -1, -1);
        expect_grant(2, 4'b0100, 8'h33,  2,  3);
        expect_grant(2, 4'b0001, 8'h11,  2,  3);
        if_c.req = 4'b0001;
        wait_grant(2, 4'b0001, "c_wait_ch0");
        if_c.req = 4'b0101;
        wait_grant(2, 4'b0100, "c_wait_ch2");
        wait_grant(2, 4'b0001, "c_wait_ch0_again");
        if_c.req = 4'b0000;
        repeat (6) @(negedge clk);
        chk("c_busy_idle", int'(mbusy[2]), 0);

        // 2: B, all request, owners change only as each drops
        expect_grant(1, 4'b0001, 8'h11, -1, -1);
        expect_grant(1, 4'b0010, 8'h22,  2, -1);
        expect_grant(1, 4'b0100, 8'h33,  2, -1);
        expect_grant(1, 4'b1000, 8'h44,  2, -1);
        expect_grant(1, 4'b0001, 8'h11,  2, -1);
        if_b.req = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            wait_grant(1, 4'(1 << c), "b_handover");
            @(negedge clk);
            chk("b_owner_held", int'(mg[1]), 1 << c);
            if_b.req[c] = 1'b0;
            @(negedge clk);
            if_b.req[c] = 1'b1;
        end
        wait_grant(1, 4'b0001, "b_wrap_ch0");
        if_b.req = 4'b0000;
        repeat (6) @(negedge clk);

        // 6: B, one-cycle pulse during TURN is never granted
        expect_grant(1, 4'b0001, 8'h11, -1, -1);
        if_b.req = 4'b0001;
        wait_grant(1, 4'b0001, "b_wait_ch0");
        if_b.req = 4'b0000;
        @(negedge clk);
        chk("b_busy_turn", int'(mbusy[1]), 1);
        chk("b_grant_turn", int'(mg[1]), 0);
        if_b.req = 4'b0010;
        @(negedge clk);
        if_b.req = 4'b0000;
        @(negedge clk);
        chk("b_back_idle", int'(mbusy[1]), 0);
        repeat (5) @(negedge clk);
        chk("b_no_pulse_grant", int'(mg[1]), 0);

        // 5: B, async reset between edges while ch1 owns
        expect_grant(1, 4'b0010, 8'h22, -1, -1);
        expect_grant(1, 4'b0001, 8'h11, -1, -1);
        if_b.req = 4'b0010;
        wait_grant(1, 4'b0010, "b_wait_ch1");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_grant", int'(mg[1]), 0);
        chk("arst_oe", int'(moe[1]), 0);
        chk("arst_busy", int'(mbusy[1]), 0);
        if_b.req = 4'b0011;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_grant(1, 4'b0001, "b_post_rst_ch0");
        if_b.req = 4'b0000;
        repeat (6) @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            chk("end_cerr", int'(mcerr[k]), 0);
            chk("end_busy", int'(mbusy[k]), 0);
        end
        chk("sb_leftover", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
- N-channel successor to the two-driver shared-output arrangement.
- Each channel registers its WIDTH-bit input, optionally inverted per channel, and may drive a single shared tristate bus.
- An internal round-robin arbiter grants bus ownership, with guaranteed high-Z turnaround between owners and optional hold-time preemption.
- Sits between channel data sources and the shared pad/bus net; replaces externally supplied per-driver active lines.

Parameters:
- CHANNELS, 2, number of drivers (2..16).
- WIDTH, 1, bus and per-channel data width.
- INVERT_MASK, {CHANNELS{1'b0}}, bit i = 1 makes channel i register the inverted input.
- TURNAROUND, 1, high-Z idle cycles between owner changes (0..15).
- MAX_HOLD, 0, cycles an owner may hold while another channel requests before preemption; 0 = unlimited.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- req  input  CHANNELS  per-channel bus request, level.
- sig_in  input  CHANNELS*WIDTH  channel data, channel i at [i*WIDTH +: WIDTH].
- sig_out  output  WIDTH  shared tristate bus.
- grant  output  CHANNELS  one-hot current owner, registered.
- busy  output  1  high in DRIVE or TURN.
- contention_err  output  1  sticky; set if more than one output enable is ever high.

Behaviour:
- Reset (rst low, async):
  - grant = 0, busy = 0, contention_err = 0, sig_out = all Z, all channel q = 0.
  - Round-robin pointer = CHANNELS-1, so channel 0 has first priority.
  - Reset asserted mid-DRIVE releases the bus immediately, not at the next edge.
- Datapath: every edge, q_i <= INVERT_MASK[i] ? ~in_i : in_i. This is independent of grant. Owner data appears on sig_out one edge after it is sampled.
- Output enable: en_i = grant[i]. Only the owning channel drives; all others are Z. contention_err sets if popcount(en) > 1. It is cleared only by reset and must stay 0 in every legal run.
- FSM IDLE:
  - grant = 0, bus Z.
  - If any req is high at the edge: pick the first requester after the pointer (cyclic), set its grant, update the pointer to it, go DRIVE.
  - Grant is visible one cycle after req is first sampled.
- FSM DRIVE:
  - Hold counter increments each cycle, saturating.
  - If req[owner] is low at the edge: grant = 0, go TURN (or arbitrate directly if TURNAROUND = 0).
  - If MAX_HOLD ≠ 0, hold count ≥ MAX_HOLD, and any other req is high: preempt, with the same release path as above.
  - Otherwise stay.
- FSM TURN:
  - Lasts exactly TURNAROUND cycles, bus Z, grant = 0.
  - At the final cycle's edge: arbitrate as in IDLE, going to DRIVE if any req is high, else IDLE.
- TURNAROUND = 0: the release edge arbitrates directly.
  - The new owner's grant is set on the same edge that clears the old one.
  - The single registered grant vector guarantees no overlap.
  - The just-released owner is eligible only if no other channel requests.
- Simultaneous requests: pure round-robin from the pointer. No channel can be starved while MAX_HOLD ≠ 0.
- Req dropped before grant: no grant is issued to that channel. Arbitration samples req only at decision edges.
- Widths:
  - Hold counter width is clog2(MAX_HOLD+1), minimum 1.
  - Turnaround counter width is clog2(TURNAROUND+1), minimum 1.

Decomposition:
- Shared package tristate_bus_pkg holds:
  - the FSM state typedef (IDLE, DRIVE, TURN);
  - a function for the next round-robin index.
- One sub-module, tristate_bus_drv (instantiated CHANNELS times), contains the per-channel register, the invert option and the tristate assign driven by en.

Test Plan:
1. Reset behaviour: CHANNELS=2, WIDTH=1, INVERT_MASK=2'b10. Hold rst low, then release; req=2'b01, sig_in=2'b11. Required: grant=01 one cycle later; sig_out=1. Then drop req[0] and raise req[1]. Required: one Z cycle, then grant=10 and sig_out=0 (inverted).
2. Contention-free handover: CHANNELS=4, WIDTH=8, TURNAROUND=2, req=4'b1111 held. Required: owners cycle 0,1,2,3,0 only as each req drops in turn. Exactly 2 Z cycles between owners. contention_err stays 0.
3. Preemption: MAX_HOLD=3, channel 0 holds req, channel 2 raises req at cycle 1. Required: channel 0 is released after 3 DRIVE cycles, then the TURNAROUND gap, then grant=0100.
4. Zero turnaround: TURNAROUND=0, req=2'b11, ch0 drops req. Required: grant goes 01 to 10 on the same edge; en never overlaps; sig_out never X.
5. Async reset mid-DRIVE: pull rst low between edges while grant=0010. Required: sig_out goes Z and grant goes 0 immediately, without waiting for clk. After release, first grant goes to channel 0 if it requests.
6. Transient request: req[1] pulses high for 1 cycle during TURN. Required: no grant to channel 1; FSM returns to IDLE.
